spi_master_shift: RTL and testbench

- SPI master shift engine that sits directly downstream of the SPI clock divider.
- Consumes the divider's clock_out as a level input (div_clk) in the same clock_in domain. Edge-detects it to pace SCLK and bit shifting.
- Full-duplex, SPI mode 0 (CPOL=0, CPHA=0), one word per transaction, valid/ready on the parallel side.

---
 rtl/spi_master_shift.sv | 135 +++++++++++++
 tb/tb_spi_master_shift.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_shift.sv
// rtl/spi_master_shift.sv - SPI mode-0 master shift engine paced by div_clk; SPI_LSB_FIRST_EN selects LSB-first
module spi_master_shift #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  div_clk,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso,
  output logic                  spi_cs_n
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state;
  logic                  div_q;
  logic                  rise_ev;
  logic                  fall_ev;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [CW-1:0]         bit_cnt;
  // Set when a transaction ends; holds CS high until one full div_clk period has elapsed.
  logic                  cs_gap;

  logic                  tx_first;
  logic [DATA_WIDTH-1:0] tx_next_sr;
  logic                  tx_next_bit;
  logic [DATA_WIDTH-1:0] rx_next_sr;

  assign rise_ev = div_clk & ~div_q;
  assign fall_ev = ~div_clk & div_q;

`ifdef SPI_LSB_FIRST_EN
  assign tx_first    = tx_data[0];
  assign tx_next_sr  = tx_sr >> 1;
  assign tx_next_bit = tx_sr[1];
  assign rx_next_sr  = {spi_miso, rx_sr[DATA_WIDTH-1:1]};
`else
  assign tx_first    = tx_data[DATA_WIDTH-1];
  assign tx_next_sr  = tx_sr << 1;
  assign tx_next_bit = tx_sr[DATA_WIDTH-2];
  assign rx_next_sr  = {rx_sr[DATA_WIDTH-2:0], spi_miso};
`endif

  // Delay div_clk by one cycle for edge detection.
  always_ff @(posedge clock_in) begin
    div_q <= div_clk;
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= IDLE;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      cs_gap   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_ev) cs_gap <= 1'b0;
          if (tx_valid && tx_ready) begin
            tx_sr    <= tx_data;
            rx_sr    <= '0;
            spi_mosi <= tx_first;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            bit_cnt  <= '0;
            // A word accepted right after the previous one keeps CS high until the gap expires.
            spi_cs_n <= cs_gap & ~rise_ev;
            state    <= SETUP;
          end else begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        SETUP: begin
          if (cs_gap) begin
            if (rise_ev) begin
              cs_gap   <= 1'b0;
              spi_cs_n <= 1'b0;
            end
          end else if (fall_ev) begin
            state <= XFER;
          end
        end
        XFER: begin
          if (rise_ev) begin
            spi_sclk <= 1'b1;
            rx_sr    <= rx_next_sr;
            bit_cnt  <= bit_cnt + CW'(1);
          end else if (fall_ev) begin
            spi_sclk <= 1'b0;
            if (bit_cnt == CW'(DATA_WIDTH)) begin
              state <= HOLD;
            end else begin
              tx_sr    <= tx_next_sr;
              spi_mosi <= tx_next_bit;
            end
          end
        end
        HOLD: begin
          spi_sclk <= 1'b0;
          if (rise_ev) begin
            spi_cs_n <= 1'b1;
            busy     <= 1'b0;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            cs_gap   <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shift.sv
// tb/tb_spi_master_shift.sv - directed self-checking bench for spi_master_shift (DIVISOR=5 divider model)
module tb_spi_master_shift;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       div_clk  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;

  logic loop_en  = 1'b0;
  logic miso_tie = 1'b0;
  logic stall    = 1'b0;
  int   div_cnt  = 0;

  int vectors     = 0;
  int miscompares = 0;

  int         rises;
  logic [7:0] mosi_bits;
  int         rxv_cnt;
  int         cs_bad;
  int         tr_bad;
  int         high_run;
  int         last_gap;
  logic [7:0] last_rx;
  logic [7:0] prev_rx;
  logic       sclk_prev = 1'b0;

  assign spi_miso = loop_en ? spi_mosi : miso_tie;

  spi_master_shift #(.DATA_WIDTH(8)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .div_clk  (div_clk),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 clock_in = ~clock_in;

  // Divide-by-5 divider model: 3 cycles low, 2 high; freezes while stall is set.
  initial begin
    forever begin
      @(negedge clock_in);
      if (!stall) begin
        div_cnt = (div_cnt == 4) ? 0 : div_cnt + 1;
        div_clk = (div_cnt >= 3);
      end
    end
  end

  // Bus monitor sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock_in);
      if (spi_sclk && !sclk_prev) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], spi_mosi};
        if (spi_cs_n) cs_bad++;
      end
      sclk_prev = spi_sclk;
      if (rx_valid) begin
        rxv_cnt++;
        prev_rx = last_rx;
        last_rx = rx_data;
      end
      if (busy && tx_ready) tr_bad++;
      if (spi_cs_n) high_run++;
      else begin
        if (high_run > 0) last_gap = high_run;
        high_run = 0;
      end
    end
  end

  function automatic logic [7:0] exp_mosi(input logic [7:0] w);
    logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic tick();
    @(negedge clock_in);
    #1;
  endtask

  task automatic clear_mon();
    rises = 0; mosi_bits = 8'h00; rxv_cnt = 0; cs_bad = 0; tr_bad = 0;
    last_rx = 8'h00; prev_rx = 8'h00; last_gap = 0;
  endtask

  task automatic start_word(input logic [7:0] w);
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin tick(); n++; end
    if (!tx_ready) begin
      miscompares++;
      $display("FAIL tx_ready_timeout: tx_ready=%0b required 1", tx_ready);
    end
    vectors++;
    tx_data  = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rxv_cnt == 0 && n < 400) begin tick(); n++; end
    if (rxv_cnt == 0) begin
      miscompares++;
      $display("FAIL done_timeout: rx_valid count=%0d required 1", rxv_cnt);
    end
    vectors++;
    tick();
    tick();
  endtask

  task automatic check_word(input string nm, input logic [7:0] rx_exp, input logic [7:0] mosi_exp);
    if (last_rx !== rx_exp) begin
      miscompares++; $display("FAIL %s_rx: got %h required %h", nm, last_rx, rx_exp);
    end
    vectors++;
    if (rxv_cnt !== 1) begin
      miscompares++; $display("FAIL %s_rxv: got %0d pulses required 1", nm, rxv_cnt);
    end
    vectors++;
    if (rises !== 8) begin
      miscompares++; $display("FAIL %s_rises: got %0d required 8", nm, rises);
    end
    vectors++;
    if (mosi_bits !== mosi_exp) begin
      miscompares++; $display("FAIL %s_mosi: got %h required %h", nm, mosi_bits, mosi_exp);
    end
    vectors++;
    if (cs_bad !== 0) begin
      miscompares++; $display("FAIL %s_cs: %0d rises with cs_n high, required 0", nm, cs_bad);
    end
    vectors++;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    if ({tx_ready, busy, rx_valid, spi_sclk, spi_mosi, spi_cs_n} !== 6'b000001) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 000001", {tx_ready, busy, rx_valid, spi_sclk, spi_mosi, spi_cs_n});
    end
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_rx_data: got %h required 00", rx_data);
    end
    vectors++;
    reset = 1'b0;
    tick();
    if (tx_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_tx_ready_after: got %b required 1", tx_ready);
    end
    vectors++;
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    clear_mon();
    start_word(8'hA5);
    wait_done();
    check_word("loop_a5", 8'hA5, exp_mosi(8'hA5));
  endtask

  task automatic test_miso_tied();
    loop_en = 1'b0;
    miso_tie = 1'b1;
    clear_mon();
    start_word(8'h00);
    wait_done();
    check_word("tie1_00", 8'hFF, 8'h00);
    miso_tie = 1'b0;
    clear_mon();
    start_word(8'hFF);
    wait_done();
    check_word("tie0_ff", 8'h00, 8'hFF);
  endtask

  task automatic test_back_to_back();
    int n;
    loop_en = 1'b1;
    clear_mon();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hC3;
    n = 0;
    while (rxv_cnt == 0 && n < 400) begin tick(); n++; end
    n = 0;
    while (!tx_ready && n < 20) begin tick(); n++; end
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (rxv_cnt < 2 && n < 400) begin tick(); n++; end
    tick();
    if (rxv_cnt !== 2) begin
      miscompares++; $display("FAIL b2b_count: got %0d pulses required 2", rxv_cnt);
    end
    vectors++;
    if ({prev_rx, last_rx} !== 16'h3CC3) begin
      miscompares++; $display("FAIL b2b_data: got %h %h required 3c c3", prev_rx, last_rx);
    end
    vectors++;
    if (last_gap < 5) begin
      miscompares++; $display("FAIL b2b_cs_gap: got %0d cycles required >=5", last_gap);
    end
    vectors++;
    if (tr_bad !== 0 || rises !== 16) begin
      miscompares++; $display("FAIL b2b_ready_rises: ready-while-busy=%0d rises=%0d required 0 and 16", tr_bad, rises);
    end
    vectors++;
  endtask

  task automatic test_reset_mid();
    int n;
    loop_en = 1'b1;
    clear_mon();
    start_word(8'h5A);
    n = 0;
    while (rises < 4 && n < 200) begin tick(); n++; end
    reset = 1'b1;
    tick();
    if ({spi_cs_n, spi_sclk, busy, rx_valid} !== 4'b1000) begin
      miscompares++; $display("FAIL rstmid_ctrl: got %b required 1000", {spi_cs_n, spi_sclk, busy, rx_valid});
    end
    vectors++;
    if (rx_data !== 8'h00) begin
      miscompares++; $display("FAIL rstmid_rx_data: got %h required 00", rx_data);
    end
    vectors++;
    tick();
    reset = 1'b0;
    repeat (20) tick();
    if (rxv_cnt !== 0) begin
      miscompares++; $display("FAIL rstmid_no_rxv: got %0d pulses required 0", rxv_cnt);
    end
    vectors++;
    clear_mon();
    start_word(8'h81);
    wait_done();
    check_word("after_rst_81", 8'h81, exp_mosi(8'h81));
  endtask

  task automatic test_stall();
    int n;
    int diffs;
    logic [2:0] snap;
    loop_en = 1'b1;
    clear_mon();
    start_word(8'h96);
    n = 0;
    while (rises < 3 && n < 200) begin tick(); n++; end
    n = 0;
    while (!div_clk && n < 20) begin tick(); n++; end
    stall = 1'b1;
    repeat (2) tick();
    snap = {spi_sclk, spi_mosi, spi_cs_n};
    diffs = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ({spi_sclk, spi_mosi, spi_cs_n} !== snap) diffs++;
    end
    if (diffs !== 0 || rises !== 3) begin
      miscompares++; $display("FAIL stall_frozen: changes=%0d rises=%0d required 0 and 3", diffs, rises);
    end
    vectors++;
    stall = 1'b0;
    wait_done();
    check_word("stall_96", 8'h96, exp_mosi(8'h96));
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first();
    loop_en = 1'b1;
    clear_mon();
    start_word(8'h01);
    wait_done();
    if (mosi_bits[7] !== 1'b1) begin
      miscompares++; $display("FAIL lsb_first_bit: got %b required 1", mosi_bits[7]);
    end
    vectors++;
    check_word("lsb_01", 8'h01, 8'h80);
  endtask
`endif

  initial begin
    clear_mon();
    high_run = 0;
    test_reset();
    test_loopback();
    test_miso_tied();
    test_back_to_back();
    test_reset_mid();
    test_stall();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
